seg7_output_conditioner: RTL and testbench

//  Sits between a 7-bit seven-segment PIO register and the HEX pins; one instance per digit.

---
 rtl/seg7_output_conditioner.sv | 85 ++++++++
 tb/tb_seg7_output_conditioner.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_output_conditioner.sv
// Per-digit conditioner between a seven-segment PIO register and the HEX pins:
// registers the active-low pattern, applies PWM dimming and blink, flags pattern changes.
module seg7_output_conditioner #(
    parameter int PWM_BITS  = 4,
    parameter int PWM_DIV   = 64,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [6:0]          seg_in,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic                blink_en,
    output logic [6:0]          hex_out,
    output logic                seg_changed
);

    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int BLK_W = $clog2(BLINK_DIV);

    typedef enum logic {SHOW = 1'b0, HIDE = 1'b1} blink_state_t;

    logic [6:0]          seg_q;
    logic [PRE_W-1:0]    prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BLK_W-1:0]    blink_cnt, blink_cnt_nxt;
    blink_state_t        state, state_nxt;
    logic                changed;
    logic                pre_wrap;
    logic                lit;

    assign changed  = (seg_in != seg_q);
    assign pre_wrap = (prescaler == PRE_W'(PWM_DIV - 1));
    // Full-scale brightness must be solidly on, which the plain compare cannot reach.
    assign lit      = (&brightness) | (pwm_cnt < brightness);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q       <= 7'h7F;
            seg_changed <= 1'b0;
            hex_out     <= 7'h7F;
        end else begin
            seg_q       <= seg_in;
            seg_changed <= changed;
            hex_out     <= seg_q | {7{~(lit & (state == SHOW))}};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else if (pre_wrap) begin
            prescaler <= '0;
            pwm_cnt   <= pwm_cnt + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SHOW;
            blink_cnt <= '0;
        end else begin
            state     <= state_nxt;
            blink_cnt <= blink_cnt_nxt;
        end
    end

    // A new pattern restarts the blink so it is always visible for a full half-period.
    always_comb begin
        state_nxt     = state;
        blink_cnt_nxt = blink_cnt;
        if (!blink_en || changed) begin
            state_nxt     = SHOW;
            blink_cnt_nxt = '0;
        end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt_nxt = '0;
            state_nxt     = (state == SHOW) ? HIDE : SHOW;
        end else begin
            blink_cnt_nxt = blink_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_output_conditioner.sv
// Bench for seg7_output_conditioner: cycle-level reference model plus directed
// hand-computed sequences for PWM, blink, change strobe and async reset.
module tb_seg7_output_conditioner;

    localparam int PWM_BITS  = 2;
    localparam int PWM_DIV   = 1;
    localparam int BLINK_DIV = 8;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [6:0]          seg_in;
    logic [PWM_BITS-1:0] brightness;
    logic                blink_en;
    logic [6:0]          hex_out;
    logic                seg_changed;

    int total = 0;
    int bad   = 0;
    logic armed = 1'b0;

    seg7_output_conditioner #(
        .PWM_BITS (PWM_BITS),
        .PWM_DIV  (PWM_DIV),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .seg_in     (seg_in),
        .brightness (brightness),
        .blink_en   (blink_en),
        .hex_out    (hex_out),
        .seg_changed(seg_changed)
    );

    always #5 clk = ~clk;

    // Reference model: time since reset drives PWM phase, time since the last
    // blink epoch (disable or new pattern) decides show/hide.
    int         cyc;
    int         age;
    logic [6:0] m_segq;
    logic [6:0] e_hex;
    logic       e_chg;

    function automatic logic [6:0] model_hex(input int c, input int a, input logic [6:0] sq,
                                             input logic [PWM_BITS-1:0] br);
        int  phase;
        bit  on;
        phase = (c / PWM_DIV) % (1 << PWM_BITS);
        on    = ((br == {PWM_BITS{1'b1}}) || (phase < int'(br))) && (((a / BLINK_DIV) % 2) == 0);
        return on ? sq : 7'h7F;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc    <= 0;
            age    <= 0;
            m_segq <= 7'h7F;
            e_hex  <= 7'h7F;
            e_chg  <= 1'b0;
        end else begin
            e_hex  <= model_hex(cyc, age, m_segq, brightness);
            e_chg  <= (seg_in != m_segq);
            age    <= (!blink_en || seg_in != m_segq) ? 0 : age + 1;
            cyc    <= cyc + 1;
            m_segq <= seg_in;
        end
    end

    task automatic chk(input string nm, input logic [6:0] got, input logic [6:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("model_hex", hex_out, e_hex);
            chk("model_chg", {6'd0, seg_changed}, {6'd0, e_chg});
        end
    end

    // Reset asserted just after a falling edge so its effect is asynchronous;
    // released on a falling edge so the next rising edge is edge 1.
    task automatic apply_reset();
        @(negedge clk);
        #1 reset_n = 1'b0;
        armed = 1'b1;
        #1 chk("reset_async", hex_out, 7'h7F);
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold", hex_out, 7'h7F);
            chk("reset_chg", {6'd0, seg_changed}, 7'd0);
        end
        reset_n = 1'b1;
    endtask

    // Blink with full brightness from release: edge 1 still shows the reset
    // pattern, then 8 edges shown, 8 hidden, repeating.
    task automatic blink_run(input string nm, input int n, input logic [6:0] pat);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk(nm, hex_out, (k == 1) ? 7'h7F : ((((k - 2) / 8) % 2) == 0 ? pat : 7'h7F));
        end
    endtask

    logic [6:0] exp2 [12];

    initial begin
        reset_n    = 1'b1;
        seg_in     = 7'h7F;
        brightness = '0;
        blink_en   = 1'b0;

        // 1: capture after reset at full brightness
        seg_in = 7'h40; brightness = 2'd3; blink_en = 1'b0;
        apply_reset();
        @(negedge clk);
        chk("t1_e1_hex", hex_out, 7'h7F);
        chk("t1_e1_chg", {6'd0, seg_changed}, 7'd1);
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            chk("t1_hex", hex_out, 7'h40);
            chk("t1_chg", {6'd0, seg_changed}, 7'd0);
        end

        // 2: 25% duty, lit on edges 5, 9, ...
        seg_in = 7'h79; brightness = 2'd1;
        exp2 = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h7F, 7'h7F, 7'h7F};
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("t2_pwm", hex_out, exp2[k]);
        end

        // 3: dark, then full brightness
        seg_in = 7'h12; brightness = 2'd0;
        apply_reset();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("t3_dark", hex_out, 7'h7F);
        end
        brightness = 2'd3;
        for (int k = 9; k <= 14; k++) begin
            @(negedge clk);
            chk("t3_full", hex_out, 7'h12);
        end

        // 4: blink, then disable mid-hide
        seg_in = 7'h24; brightness = 2'd3; blink_en = 1'b1;
        apply_reset();
        blink_run("t4_blink", 25, 7'h24);
        for (int k = 26; k <= 28; k++) begin
            @(negedge clk);
            chk("t4_hide", hex_out, 7'h7F);
        end
        blink_en = 1'b0;
        @(negedge clk);
        for (int k = 30; k <= 33; k++) begin
            @(negedge clk);
            chk("t4_restore", hex_out, 7'h24);
        end

        // 5: new pattern during hide restarts a full show phase
        blink_en = 1'b1;
        apply_reset();
        blink_run("t5_pre", 12, 7'h24);
        seg_in = 7'h30;
        @(negedge clk);
        chk("t5_e13_hex", hex_out, 7'h7F);
        chk("t5_e13_chg", {6'd0, seg_changed}, 7'd1);
        for (int k = 14; k <= 21; k++) begin
            @(negedge clk);
            chk("t5_show", hex_out, 7'h30);
            chk("t5_chg", {6'd0, seg_changed}, 7'd0);
        end
        @(negedge clk);
        chk("t5_blank", hex_out, 7'h7F);

        // 6: reset mid-show, then a fresh show phase
        seg_in = 7'h24;
        apply_reset();
        blink_run("t6_pre", 5, 7'h24);
        apply_reset();
        blink_run("t6_post", 25, 7'h24);

        // 7: all-off pattern still counts as a change
        blink_en = 1'b0;
        repeat (3) @(negedge clk);
        seg_in = 7'h7F;
        @(negedge clk);
        chk("t7_chg", {6'd0, seg_changed}, 7'd1);
        @(negedge clk);
        chk("t7_hex", hex_out, 7'h7F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
